// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant and bounded grant hold.
// Optional lock input (holder keeps grant while locked) enabled by defining RR_ARB_LOCK_EN.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int ID_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
`ifdef RR_ARB_LOCK_EN
    input  logic [N-1:0]    lock,
`endif
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    localparam int HC_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic [N-1:0]    others;
    logic [ID_W-1:0] nxt;
    logic [ID_W-1:0] win;
    logic            lock_hold;

    function automatic logic [ID_W-1:0] inc_idx(input logic [ID_W-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    // First set bit of r searching circularly from start.
    function automatic logic [ID_W-1:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] start);
        logic [ID_W-1:0] w;
        logic            hit;
        int              idx;
        w   = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start) + i;
            if (idx >= N) idx = idx - N;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                w   = ID_W'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

`ifdef RR_ARB_LOCK_EN
    assign lock_hold = lock[gnt_id_q];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        win         = '0;
        others      = req & ~gnt_q;
        nxt         = inc_idx(gnt_id_q);

        if (!gnt_valid_q) begin
            if (|req) begin
                win         = pick(req, ptr_q);
                gnt_d       = onehot(win);
                gnt_id_d    = win;
                gnt_valid_d = 1'b1;
                hold_d      = '0;
            end
        end else if (!req[gnt_id_q]) begin
            // Holder released: hand off on the same edge if anyone else waits.
            ptr_d  = nxt;
            hold_d = '0;
            if (|req) begin
                win      = pick(req, nxt);
                gnt_d    = onehot(win);
                gnt_id_d = win;
            end else begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        end else if (lock_hold) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        end else if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (|others) begin
                ptr_d    = nxt;
                win      = pick(others, nxt);
                gnt_d    = onehot(win);
                gnt_id_d = win;
            end
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
// Lock scenario is exercised only when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_b;
    logic [3:0] gnt, gnt_b;
    logic [1:0] gnt_id, gnt_id_b;
    logic       gnt_valid, gnt_valid_b;
`ifdef RR_ARB_LOCK_EN
    logic [3:0] lock;
    logic [3:0] lock_b;
`endif

    int checks   = 0;
    int failures = 0;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock_b),
`endif
        .gnt       (gnt_b),
        .gnt_id    (gnt_id_b),
        .gnt_valid (gnt_valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eg, input logic [1:0] eid, input logic ev);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(ev));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        req_b = 4'b0000;
`ifdef RR_ARB_LOCK_EN
        lock   = 4'b0000;
        lock_b = 4'b0000;
`endif
        step();

        // Reset holds grant low even with all requests asserted
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("reset_hold", 4'b0000, 2'd0, 1'b0);
        end
        rst = 1'b0;
        step();
        chk_a("first_after_reset", 4'b0001, 2'd0, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk_a("reset_mid_grant", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        step();
        chk_a("idle_after_reset", 4'b0000, 2'd0, 1'b0);

        // Single requester keeps grant indefinitely
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_a("single", 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        step();
        chk_a("single_release", 4'b0000, 2'd0, 1'b0);

        // Hold limit alternates 0 and 1 every four cycles (ptr is 3, winner wraps to 0)
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            if (((i / 4) % 2) == 0) chk_a("hold_limit", 4'b0001, 2'd0, 1'b1);
            else                    chk_a("hold_limit", 4'b0010, 2'd1, 1'b1);
        end

        // Holder 0 drops while 1 and 2 request: no idle bubble
        req = 4'b0110;
        step();
        chk_a("handoff", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        step();
        chk_a("handoff_idle", 4'b0000, 2'd0, 1'b0);

        // Pure round robin with MAX_HOLD=1
        req_b = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fair.gnt", 32'(gnt_b), 32'(4'b0001 << (i % 4)));
            chk("fair.id", 32'(gnt_id_b), 32'(i % 4));
            chk("fair.valid", 32'(gnt_valid_b), 32'(1'b1));
        end
        req_b = 4'b0000;
        step();
        chk("fair_idle.gnt", 32'(gnt_b), 32'(4'b0000));

`ifdef RR_ARB_LOCK_EN
        // Locked holder 0 keeps grant past the hold limit; rotates when lock drops
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_a("lock_hold", 4'b0001, 2'd0, 1'b1);
        end
        lock = 4'b0000;
        step();
        chk_a("lock_release", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
